dmac_ctrl_arbiter: RTL and testbench

// Shares the single DMA control target among NB_CORES core-side control ports.

---
 rtl/dmac_ctrl_arbiter_if.sv | 50 +++++
 rtl/dmac_ctrl_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmac_ctrl_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dmac_ctrl_arbiter_if.sv
// Control-bus bundle between the per-core ports, the arbiter and the DMA control target.
// Latency: none (wires only).
// Backpressure: req/gnt handshake on both sides; responses are never stalled.
interface dmac_ctrl_arbiter_if #(
  parameter int NB_CORES   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 5
);
  // core side, flattened per core
  logic [NB_CORES-1:0]            slv_req;
  logic [NB_CORES*ADDR_WIDTH-1:0] slv_add;
  logic [NB_CORES-1:0]            slv_wen;
  logic [NB_CORES*BE_WIDTH-1:0]   slv_be;
  logic [NB_CORES*DATA_WIDTH-1:0] slv_wdata;
  logic [NB_CORES*ID_WIDTH-1:0]   slv_id;
  logic [NB_CORES-1:0]            slv_gnt;
  logic [NB_CORES-1:0]            slv_r_valid;
  logic [DATA_WIDTH-1:0]          slv_r_rdata;
  logic [ID_WIDTH-1:0]            slv_r_id;

  // DMA control target side
  logic                           mst_req;
  logic [ADDR_WIDTH-1:0]          mst_add;
  logic                           mst_wen;
  logic [BE_WIDTH-1:0]            mst_be;
  logic [DATA_WIDTH-1:0]          mst_wdata;
  logic [ID_WIDTH-1:0]            mst_id;
  logic                           mst_gnt;
  logic                           mst_r_valid;
  logic [DATA_WIDTH-1:0]          mst_r_rdata;
  logic [ID_WIDTH-1:0]            mst_r_id;

  // arbiter view: serves the cores, drives the DMA target
  modport slave (
    input  slv_req, slv_add, slv_wen, slv_be, slv_wdata, slv_id,
    output slv_gnt, slv_r_valid, slv_r_rdata, slv_r_id,
    output mst_req, mst_add, mst_wen, mst_be, mst_wdata, mst_id,
    input  mst_gnt, mst_r_valid, mst_r_rdata, mst_r_id
  );

  // environment view: the cores plus the DMA control target
  modport master (
    output slv_req, slv_add, slv_wen, slv_be, slv_wdata, slv_id,
    input  slv_gnt, slv_r_valid, slv_r_rdata, slv_r_id,
    input  mst_req, mst_add, mst_wen, mst_be, mst_wdata, mst_id,
    output mst_gnt, mst_r_valid, mst_r_rdata, mst_r_id
  );
endinterface

// File: rtl/dmac_ctrl_arbiter.sv
// Round-robin, lock-on-stall arbiter sharing the DMA control target among NB_CORES cores.
// Latency: 0 cycles for request/grant and for response routing (pure pass-through).
// Backpressure: a stalled winner is held until granted; requests stall while OUTSTND are unanswered.
module dmac_ctrl_arbiter #(
  parameter int NB_CORES   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 5,
  parameter int OUTSTND    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  dmac_ctrl_arbiter_if.slave  bus,
  output logic                busy_o,
  output logic                err_o
);
  localparam int IDX_W = $clog2(NB_CORES);
  localparam int PTR_W = $clog2(OUTSTND);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             lock;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] next_ptr;
  logic             have_req;
  logic             hs;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] head;

  // route FIFO: index of the core owning each granted-but-unanswered request
  logic [IDX_W-1:0] route_mem [OUTSTND];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign fifo_full  = (count == CNT_W'(OUTSTND));
  assign fifo_empty = (count == '0);
  assign head       = route_mem[rd_ptr];
  assign busy_o     = !fifo_empty;

  // pick the winner: a locked core keeps the bus, else first requester at or after rr_ptr
  always_comb begin
    winner   = rr_ptr;
    cand     = rr_ptr;
    have_req = 1'b0;
    if (lock) begin
      winner   = lock_idx;
      have_req = 1'b1;
    end else begin
      // walk downward so the closest requester to rr_ptr is assigned last
      for (int k = NB_CORES - 1; k >= 0; k--) begin
        cand = IDX_W'((int'(rr_ptr) + k) % NB_CORES);
        if (bus.slv_req[cand]) begin
          winner   = cand;
          have_req = 1'b1;
        end
      end
    end
    next_ptr = IDX_W'((int'(winner) + 1) % NB_CORES);
  end

  // a full route FIFO blocks the request so no response can lose its owner
  assign bus.mst_req = have_req && !fifo_full;
  assign hs          = bus.mst_req && bus.mst_gnt;
  assign pop         = bus.mst_r_valid && !fifo_empty;

  assign bus.slv_r_rdata = bus.mst_r_rdata;
  assign bus.slv_r_id    = bus.mst_r_id;

  // mux winner fields to the target, return grant to winner and response to FIFO head
  always_comb begin
    bus.mst_add     = '0;
    bus.mst_wen     = 1'b0;
    bus.mst_be      = '0;
    bus.mst_wdata   = '0;
    bus.mst_id      = '0;
    bus.slv_gnt     = '0;
    bus.slv_r_valid = '0;
    for (int c = 0; c < NB_CORES; c++) begin
      if (winner == IDX_W'(c)) begin
        bus.mst_add   = bus.slv_add[c*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mst_wen   = bus.slv_wen[c];
        bus.mst_be    = bus.slv_be[c*BE_WIDTH +: BE_WIDTH];
        bus.mst_wdata = bus.slv_wdata[c*DATA_WIDTH +: DATA_WIDTH];
        bus.mst_id    = bus.slv_id[c*ID_WIDTH +: ID_WIDTH];
        bus.slv_gnt[c] = hs;
      end
      if (head == IDX_W'(c)) begin
        bus.slv_r_valid[c] = pop;
      end
    end
  end

  // round-robin pointer and stall lock
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (hs) begin
      rr_ptr <= next_ptr;
      lock   <= 1'b0;
    end else if (bus.mst_req) begin
      lock     <= 1'b1;
      lock_idx <= winner;
    end
  end

  // route FIFO storage, no reset needed since count gates every read
  always_ff @(posedge clk_i) begin
    if (hs) begin
      route_mem[wr_ptr] <= winner;
    end
  end

  // route FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (hs) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // sticky error: a response arrived that nobody is waiting for
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (bus.mst_r_valid && fifo_empty) begin
      err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dmac_ctrl_arbiter.sv
// Randomized bench for dmac_ctrl_arbiter against a queue-based reference model.
// Inputs driven on the falling edge, outputs sampled 1ns later.
// Ends with error/reset scenario and a fairness check after reset.
module tb_dmac_ctrl_arbiter;
  localparam int NB  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int IW  = 5;
  localparam int OUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  dmac_ctrl_arbiter_if #(.NB_CORES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .BE_WIDTH(BW), .ID_WIDTH(IW)) bus ();

  dmac_ctrl_arbiter #(.NB_CORES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .BE_WIDTH(BW), .ID_WIDTH(IW), .OUTSTND(OUT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .busy_o (busy),
    .err_o  (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state: owners of outstanding requests in grant order
  int m_q[$];
  int m_ptr;
  int m_lock;   // -1 when no core holds the bus
  bit m_err;

  // per-core pending request and its fields
  bit            pend [NB];
  logic [AW-1:0] f_add [NB];
  logic          f_wen [NB];
  logic [BW-1:0] f_be [NB];
  logic [DW-1:0] f_wd [NB];
  logic [IW-1:0] f_id [NB];

  task automatic model_reset();
    m_q.delete();
    m_ptr  = 0;
    m_lock = -1;
    m_err  = 1'b0;
    for (int c = 0; c < NB; c++) pend[c] = 1'b0;
  endtask

  task automatic drive_idle();
    bus.slv_req     = '0;
    bus.slv_add     = '0;
    bus.slv_wen     = '0;
    bus.slv_be      = '0;
    bus.slv_wdata   = '0;
    bus.slv_id      = '0;
    bus.mst_gnt     = 1'b0;
    bus.mst_r_valid = 1'b0;
    bus.mst_r_rdata = '0;
    bus.mst_r_id    = '0;
  endtask

  // one clock: percentages for new request, target grant, response; bad_rsp forces r_valid
  task automatic cycle(input int p_new, input int p_gnt, input int p_rsp, input bit bad_rsp);
    int            w;
    bit            have;
    bit            full;
    bit            gnt;
    bit            rv;
    bit            exp_req;
    bit            hs;
    bit            rsp_ok;
    logic [NB-1:0] exp_gnt;
    logic [NB-1:0] exp_rv;
    logic [DW-1:0] rd;
    logic [IW-1:0] rid;

    @(negedge clk);
    for (int c = 0; c < NB; c++) begin
      if (!pend[c] && ($urandom_range(99) < p_new)) begin
        pend[c]  = 1'b1;
        f_add[c] = $urandom;
        f_wen[c] = 1'($urandom_range(1));
        f_be[c]  = BW'($urandom);
        f_wd[c]  = $urandom;
        f_id[c]  = IW'($urandom);
      end
      bus.slv_req[c]              = pend[c];
      bus.slv_add[c*AW +: AW]     = f_add[c];
      bus.slv_wen[c]              = f_wen[c];
      bus.slv_be[c*BW +: BW]      = f_be[c];
      bus.slv_wdata[c*DW +: DW]   = f_wd[c];
      bus.slv_id[c*IW +: IW]      = f_id[c];
    end
    gnt = ($urandom_range(99) < p_gnt);
    rv  = bad_rsp || ((m_q.size() != 0) && ($urandom_range(99) < p_rsp));
    rd  = $urandom;
    rid = IW'($urandom);
    bus.mst_gnt     = gnt;
    bus.mst_r_valid = rv;
    bus.mst_r_rdata = rd;
    bus.mst_r_id    = rid;
    #1;

    // expected behaviour from the arbitration rules
    w    = 0;
    have = 1'b0;
    if (m_lock >= 0) begin
      w    = m_lock;
      have = 1'b1;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (!have && pend[(m_ptr + k) % NB]) begin
          w    = (m_ptr + k) % NB;
          have = 1'b1;
        end
      end
    end
    full    = (m_q.size() == OUT);
    exp_req = have && !full;
    hs      = exp_req && gnt;
    rsp_ok  = rv && (m_q.size() != 0);
    exp_gnt = '0;
    exp_rv  = '0;
    if (hs) exp_gnt[w] = 1'b1;
    if (rsp_ok) exp_rv[m_q[0]] = 1'b1;

    check_eq("mst_req", 64'(bus.mst_req), 64'(exp_req));
    check_eq("slv_gnt", 64'(bus.slv_gnt), 64'(exp_gnt));
    check_eq("slv_r_valid", 64'(bus.slv_r_valid), 64'(exp_rv));
    check_eq("busy", 64'(busy), 64'(m_q.size() != 0));
    check_eq("err", 64'(err), 64'(m_err));
    if (rv) begin
      check_eq("r_rdata", 64'(bus.slv_r_rdata), 64'(rd));
      check_eq("r_id", 64'(bus.slv_r_id), 64'(rid));
    end
    if (exp_req) begin
      check_eq("mst_add", 64'(bus.mst_add), 64'(f_add[w]));
      check_eq("mst_wen", 64'(bus.mst_wen), 64'(f_wen[w]));
      check_eq("mst_be", 64'(bus.mst_be), 64'(f_be[w]));
      check_eq("mst_wdata", 64'(bus.mst_wdata), 64'(f_wd[w]));
      check_eq("mst_id", 64'(bus.mst_id), 64'(f_id[w]));
    end

    // advance the model to the coming rising edge
    if (rv && (m_q.size() == 0)) m_err = 1'b1;
    if (rsp_ok) void'(m_q.pop_front());
    if (hs) begin
      m_q.push_back(w);
      m_ptr   = (w + 1) % NB;
      m_lock  = -1;
      pend[w] = 1'b0;
    end else if (exp_req) begin
      m_lock = w;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_err", 64'(err), 64'(0));
    check_eq("rst_mst_req", 64'(bus.mst_req), 64'(0));
    rst_n = 1'b1;
  endtask

  initial begin
    drive_idle();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("init_busy", 64'(busy), 64'(0));
    check_eq("init_err", 64'(err), 64'(0));
    check_eq("init_gnt", 64'(bus.slv_gnt), 64'(0));
    rst_n = 1'b1;

    cycle(0, 0, 0, 1'b0);                            // idle after reset
    repeat (200) cycle(40, 60, 40, 1'b0);            // mixed traffic with stalls
    repeat (200) cycle(90, 100, 8, 1'b0);            // slow responses fill the route FIFO
    repeat (150) cycle(70, 50, 60, 1'b0);            // heavy contention, frequent stalls
    repeat (30) cycle(0, 100, 100, 1'b0);            // drain everything
    cycle(0, 100, 0, 1'b1);                          // stray response
    cycle(0, 100, 0, 1'b0);                          // err visible now
    check_eq("err_sticky", 64'(err), 64'(1));
    reset_pulse();
    repeat (8) cycle(100, 100, 50, 1'b0);            // core0 first after reset, then alternate
    repeat (30) cycle(0, 100, 100, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
